array_rw_sched: RTL and testbench
=================================

ARRAY_RW_SCHED -- requirements
Module: array_rw_sched

Purpose: sequences a 128-entry x 106-bit single-port BPU array (2 ways x 53 bits, per-way write mask). Provides power-on clearing, read/write arbitration, a 1-entry write buffer and read-after-write forwarding.

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, the number of consecutive read-won cycles after which a buffered write is forced.
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 r_req_valid/r_req_ready/r_req_idx  in/out/in  1/1/7  read request handshake and set index.
REQ-006 r_resp_valid/r_resp_data  out/out  1/106  read response; way0 in [52:0], way1 in [105:53].
REQ-007 w_req_valid/w_req_ready/w_req_idx/w_req_data/w_req_waymask  in/out/in/in/in  1/1/7/53/2  write request; data is replicated to every way selected by the mask.
REQ-008 init_done  out  1  high once the array clear has completed.
REQ-009 sram_en/sram_wmode/sram_addr/sram_wmask/sram_wdata  out  1/1/7/2/106  array port controls.
REQ-010 sram_rdata  in  106  array read data, valid the cycle after a read enable.

Function
REQ-011 The FSM SHALL have two states, INIT and RUN; reset SHALL force INIT with the clear counter at 0.
REQ-012 In INIT, each cycle SHALL drive sram_en=1, sram_wmode=1, sram_addr=counter, sram_wmask=2'b11 and sram_wdata=0, then increment the counter.
REQ-013 The FSM SHALL move to RUN after the write to address 127; the 7-bit counter SHALL wrap to 0 at that point.
REQ-014 In INIT, r_req_ready, w_req_ready and init_done SHALL be 0; init_done SHALL be 1 in RUN.
REQ-015 The write buffer SHALL hold one entry: valid flag, idx, 53-bit data and 2-bit mask.
REQ-016 A read fires on r_req_valid && r_req_ready; a write is accepted on w_req_valid && w_req_ready.
REQ-017 In RUN, port priority SHALL be: forced write (buffer valid and starve count == STARVE_LIMIT), then read, then buffered write, then idle.
REQ-018 r_req_ready SHALL be 1 in RUN unless a forced write is pending.
REQ-019 Drain SHALL mean the buffered write is issued this cycle (buffer valid and no read fires).
REQ-020 w_req_ready SHALL be 1 in RUN when the buffer is empty or draining this cycle.
REQ-021 An accepted write SHALL be loaded into the buffer at the next edge; an accept and a drain in the same cycle SHALL both take effect.
REQ-022 A read issue SHALL drive sram_en=1, sram_wmode=0, sram_addr=r_req_idx.
REQ-023 A write issue SHALL drive sram_en=1, sram_wmode=1, sram_addr=buf idx, sram_wmask=buf mask and sram_wdata={buf data, buf data}.
REQ-024 When idle, the block SHALL drive sram_en=0 with all other port controls 0.
REQ-025 r_resp_valid SHALL be asserted exactly one cycle after a read fires; there is no backpressure on the response.
REQ-026 Forwarding: if the buffer is valid with a matching idx when a read fires, each way whose mask bit is set SHALL return the buffered data in the response; other ways SHALL return sram_rdata.
REQ-027 A write accepted in the same cycle as a read to the same idx SHALL NOT be forwarded; the read is ordered first.
REQ-028 The starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle the buffer is valid and a read fires, and clear to 0 when the buffer drains or is empty.
REQ-029 A forced write SHALL complete in one cycle, after which reads resume.
REQ-030 Only the 7 LSBs of every index are used; there is no out-of-range condition.

Reset
REQ-031 While reset_n is low, outputs SHALL be: r_req_ready=0, w_req_ready=0, r_resp_valid=0, init_done=0, sram_en=0, and all other outputs 0.
REQ-032 Reset asserted mid-operation SHALL drop the buffered write and any pending response, return the FSM to INIT and re-clear all 128 entries.
REQ-033 The first INIT write SHALL occur in the first clock cycle after reset_n rises.

Verification
REQ-034 Release reset, hold no requests -> exactly 128 zero writes to addresses 0..127, then init_done=1 on cycle 129; reading idx 5 returns 0.
REQ-035 Write idx 9, data 0x1ABC, mask 2'b01, with reads idle -> array write issued the next cycle; a later read of 9 returns way0=0x1ABC, way1=0.
REQ-036 Write idx 3, mask 2'b10, then read idx 3 continuously -> the first response forwards way1 data; the write is forced after 4 read-won cycles; r_req_ready=0 for exactly that one cycle.
REQ-037 Buffer full and blocked by reads, a second write is presented -> w_req_ready=0 until the drain cycle; in the drain cycle the new write is accepted and then drained in order.
REQ-038 Same-cycle read idx 7 and write accept idx 7 -> the response carries the pre-write data; a subsequent read returns the new data.
REQ-039 Pulse reset_n low at cycle 60 of INIT, and separately with the buffer valid in RUN -> INIT restarts at address 0, the buffered write is never issued, and r_resp_valid stays 0.

Source files
------------

// File: rtl/array_rw_sched.sv
// Sequencer for a 128 x 106-bit single-port BPU array (2 ways x 53 bits): clears the
// array after reset, then arbitrates reads against a one-entry write buffer with forwarding.
module array_rw_sched #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         r_req_valid,
   output logic         r_req_ready,
   input  logic [6:0]   r_req_idx,
   output logic         r_resp_valid,
   output logic [105:0] r_resp_data,
   input  logic         w_req_valid,
   output logic         w_req_ready,
   input  logic [6:0]   w_req_idx,
   input  logic [52:0]  w_req_data,
   input  logic [1:0]   w_req_waymask,
   output logic         init_done,
   output logic         sram_en,
   output logic         sram_wmode,
   output logic [6:0]   sram_addr,
   output logic [1:0]   sram_wmask,
   output logic [105:0] sram_wdata,
   input  logic [105:0] sram_rdata
);
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   typedef enum logic {INIT, RUN} state_t;

   typedef struct packed {
      logic        vld;
      logic [6:0]  idx;
      logic [52:0] data;
      logic [1:0]  mask;
   } wbuf_t;

   state_t        state_q;
   logic [6:0]    cnt_q;
   wbuf_t         wbuf_q, wbuf_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          resp_vld_q;
   logic [1:0]    fwd_mask_q;
   logic [52:0]   fwd_data_q;

   logic run, forced, rd_fire, drain, w_acc, fwd_hit;

   assign run         = (state_q == RUN);
   assign forced      = run && wbuf_q.vld && (starve_q == LIM);
   assign r_req_ready = run && !forced;
   assign rd_fire     = r_req_valid && r_req_ready;
   // A forced write is just a drain that reads could not pre-empt.
   assign drain       = run && wbuf_q.vld && !rd_fire;
   assign w_req_ready = run && (!wbuf_q.vld || drain);
   assign w_acc       = w_req_valid && w_req_ready;
   assign fwd_hit     = wbuf_q.vld && (wbuf_q.idx == r_req_idx);
   assign init_done   = run;

   always_comb begin
      wbuf_d = wbuf_q;
      if (drain) wbuf_d.vld = 1'b0;
      if (w_acc) begin
         wbuf_d.vld  = 1'b1;
         wbuf_d.idx  = w_req_idx;
         wbuf_d.data = w_req_data;
         wbuf_d.mask = w_req_waymask;
      end
   end

   always_comb begin
      starve_d = '0;
      if (wbuf_q.vld && rd_fire)
         starve_d = (starve_q == LIM) ? LIM : starve_q + SW'(1);
   end

   // Port mux; reset_n gates the clear writes so the port stays quiet while held in reset.
   always_comb begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wmask = '0;
      sram_wdata = '0;
      if (state_q == INIT) begin
         if (reset_n) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = cnt_q;
            sram_wmask = 2'b11;
         end
      end else if (rd_fire) begin
         sram_en   = 1'b1;
         sram_addr = r_req_idx;
      end else if (wbuf_q.vld) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = wbuf_q.idx;
         sram_wmask = wbuf_q.mask;
         sram_wdata = {wbuf_q.data, wbuf_q.data};
      end
   end

   always_comb begin
      r_resp_data = '0;
      if (resp_vld_q) begin
         r_resp_data[52:0]   = fwd_mask_q[0] ? fwd_data_q : sram_rdata[52:0];
         r_resp_data[105:53] = fwd_mask_q[1] ? fwd_data_q : sram_rdata[105:53];
      end
   end
   assign r_resp_valid = resp_vld_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         wbuf_q     <= '0;
         starve_q   <= '0;
         resp_vld_q <= 1'b0;
         fwd_mask_q <= '0;
         fwd_data_q <= '0;
      end else begin
         if (state_q == INIT) begin
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q == 7'd127) state_q <= RUN;
         end
         wbuf_q     <= wbuf_d;
         starve_q   <= starve_d;
         resp_vld_q <= rd_fire;
         // Capture the buffer as it stood before this edge, so a same-cycle accept is not forwarded.
         if (rd_fire) begin
            fwd_mask_q <= fwd_hit ? wbuf_q.mask : 2'b00;
            fwd_data_q <= wbuf_q.data;
         end
      end
   end
endmodule

// File: tb/tb_array_rw_sched.sv
// Bench for array_rw_sched: array memory model, program-order reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_array_rw_sched;
   localparam int LIM = 4;
   localparam logic [52:0] D3  = 53'h1F_0000_ABCD;
   localparam logic [52:0] D20 = 53'h0A_5555_1234;
   localparam logic [52:0] D21 = 53'h13_7777_9876;
   localparam logic [52:0] X7  = 53'h05_1111_2222;
   localparam logic [52:0] Y7  = 53'h0C_3333_4444;
   localparam logic [52:0] D40 = 53'h1E_DEAD_BEEF;

   typedef struct packed {
      logic [6:0]  idx;
      logic [52:0] d;
      logic [1:0]  m;
   } wr_t;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         r_req_valid, r_req_ready;
   logic [6:0]   r_req_idx;
   logic         r_resp_valid;
   logic [105:0] r_resp_data;
   logic         w_req_valid, w_req_ready;
   logic [6:0]   w_req_idx;
   logic [52:0]  w_req_data;
   logic [1:0]   w_req_waymask;
   logic         init_done;
   logic         sram_en, sram_wmode;
   logic [6:0]   sram_addr;
   logic [1:0]   sram_wmask;
   logic [105:0] sram_wdata, sram_rdata;

   int checks = 0;
   int errors = 0;

   array_rw_sched #(.STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset_n(reset_n),
      .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_idx(r_req_idx),
      .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
      .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_idx(w_req_idx),
      .w_req_data(w_req_data), .w_req_waymask(w_req_waymask),
      .init_done(init_done),
      .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [105:0] rnd106();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[105:0];
   endfunction

   function automatic logic [105:0] bits_of(input logic [1:0] m);
      return {{53{m[1]}}, {53{m[0]}}};
   endfunction

   // Array itself: masked write, one-cycle read latency, garbage on non-read cycles.
   logic [105:0] mem [128];
   always @(posedge clock) begin
      if (sram_en && sram_wmode)
         mem[sram_addr] <= (mem[sram_addr] & ~bits_of(sram_wmask)) | (sram_wdata & bits_of(sram_wmask));
      if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
      else                        sram_rdata <= rnd106();
   end

   // Reference: logical array contents in program order, pending writes as a queue.
   logic [105:0] L [128];
   wr_t          bq[$];
   wr_t          b;
   int           m_addr, m_starve;
   logic         m_rv;
   logic [105:0] m_rd;
   logic         forced, rd, drain, wacc;
   logic [116:0] eport;

   always @(negedge clock) begin
      if (!reset_n) begin
         chk("reset_ctl", {r_req_ready, w_req_ready, r_resp_valid, init_done,
                           sram_en, sram_wmode, sram_addr, sram_wmask}, '0);
         chk("reset_wdata", sram_wdata, '0);
         chk("reset_rdata", r_resp_data, '0);
         m_addr = 0; m_starve = 0; m_rv = 1'b0;
         bq.delete();
         for (int i = 0; i < 128; i++) L[i] = '0;
      end else begin
         chk("resp_valid", r_resp_valid, m_rv);
         if (m_rv) chk("resp_data", r_resp_data, m_rd);
         m_rv = 1'b0;
         if (m_addr < 128) begin
            chk("init_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
                {2'b11, 7'(m_addr), 2'b11, 106'b0});
            chk("init_hs", {r_req_ready, w_req_ready, init_done}, 3'b000);
            m_addr++;
         end else begin
            forced = (bq.size() != 0) && (m_starve == LIM);
            rd     = r_req_valid && !forced;
            drain  = (bq.size() != 0) && !rd;
            wacc   = w_req_valid && ((bq.size() == 0) || drain);
            eport  = '0;
            if (rd) eport = {2'b10, r_req_idx, 2'b00, 106'b0};
            else if (drain) begin
               b = bq[0];
               eport = {2'b11, b.idx, b.m, b.d, b.d};
            end
            chk("run_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, eport);
            chk("run_hs", {r_req_ready, w_req_ready, init_done},
                {!forced, (bq.size() == 0) || drain, 1'b1});
            if (rd) begin
               m_rv = 1'b1;
               m_rd = L[r_req_idx];
            end
            if ((bq.size() != 0) && rd) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else                        m_starve = 0;
            if (drain) void'(bq.pop_front());
            if (wacc) begin
               bq.push_back('{idx: w_req_idx, d: w_req_data, m: w_req_waymask});
               if (w_req_waymask[0]) L[w_req_idx][52:0]   = w_req_data;
               if (w_req_waymask[1]) L[w_req_idx][105:53] = w_req_data;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [5:0]  rdy_pat;
   logic [4:0]  wrdy_pat;
   logic [63:0] r64;

   initial begin
      reset_n = 1'b0;
      r_req_valid = 1'b0; r_req_idx = '0;
      w_req_valid = 1'b0; w_req_idx = '0; w_req_data = '0; w_req_waymask = '0;
      sram_rdata = '0;
      for (int i = 0; i < 128; i++) mem[i] = rnd106();
      repeat (3) step();
      #2 chk("rst_outs", {r_req_ready, w_req_ready, init_done, sram_en, r_resp_valid}, 5'b0);

      // Reset pulse in the middle of the clear sequence.
      step(); reset_n = 1'b1;
      #2 chk("init_first", {sram_en, sram_wmode, sram_addr}, {2'b11, 7'd0});
      repeat (59) step();
      reset_n = 1'b0;
      step(); reset_n = 1'b1;

      for (int c = 0; c < 128; c++) begin
         #2 chk("init_addr", {sram_en, sram_wmode, sram_addr, sram_wdata}, {2'b11, 7'(c), 106'b0});
         step();
      end
      #2 chk("init_done_129", init_done, 1'b1);

      r_req_valid = 1'b1; r_req_idx = 7'd5;
      step(); r_req_valid = 1'b0;
      #2 chk("rd5", {r_resp_valid, r_resp_data}, {1'b1, 106'b0});

      // Write with reads idle: issued the very next cycle.
      step();
      w_req_valid = 1'b1; w_req_idx = 7'd9; w_req_data = 53'h1ABC; w_req_waymask = 2'b01;
      #2 chk("w9_ready", w_req_ready, 1'b1);
      step(); w_req_valid = 1'b0;
      #2 chk("w9_issue", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
             {2'b11, 7'd9, 2'b01, 53'h1ABC, 53'h1ABC});
      step(); r_req_valid = 1'b1; r_req_idx = 7'd9;
      step(); r_req_valid = 1'b0;
      #2 chk("rd9", r_resp_data, {53'h0, 53'h1ABC});

      // Starvation: four read-won cycles, then one forced-write cycle.
      step();
      w_req_valid = 1'b1; w_req_idx = 7'd3; w_req_data = D3; w_req_waymask = 2'b10;
      step(); w_req_valid = 1'b0; r_req_valid = 1'b1; r_req_idx = 7'd3;
      for (int c = 0; c < 6; c++) begin
         #2 rdy_pat[5-c] = r_req_ready;
         if (c == 1) chk("fwd3", r_resp_data, {D3, 53'h0});
         if (c == 4) chk("force3", {sram_en, sram_wmode, sram_addr, sram_wmask}, {2'b11, 7'd3, 2'b10});
         step();
      end
      chk("starve_rdy", rdy_pat, 6'b111101);
      r_req_valid = 1'b0;

      // Second write waits behind a starved buffer, accepted in the drain cycle.
      step();
      w_req_valid = 1'b1; w_req_idx = 7'd20; w_req_data = D20; w_req_waymask = 2'b11;
      step();
      w_req_idx = 7'd21; w_req_data = D21; w_req_waymask = 2'b01;
      r_req_valid = 1'b1; r_req_idx = 7'd30;
      for (int c = 0; c < 5; c++) begin
         #2 wrdy_pat[4-c] = w_req_ready;
         if (c == 4) chk("force20", {sram_en, sram_wmode, sram_addr}, {2'b11, 7'd20});
         step();
      end
      chk("wrdy_pat", wrdy_pat, 5'b00001);
      w_req_valid = 1'b0; r_req_valid = 1'b0;
      #2 chk("drain21", {sram_en, sram_wmode, sram_addr, sram_wmask}, {2'b11, 7'd21, 2'b01});

      // Same-cycle read and write to idx 7: read sees the older value.
      step();
      w_req_valid = 1'b1; w_req_idx = 7'd7; w_req_data = X7; w_req_waymask = 2'b11;
      step(); w_req_valid = 1'b0;
      step();
      r_req_valid = 1'b1; r_req_idx = 7'd7;
      w_req_valid = 1'b1; w_req_idx = 7'd7; w_req_data = Y7; w_req_waymask = 2'b11;
      #2 chk("rw7_ready", {r_req_ready, w_req_ready}, 2'b11);
      step(); w_req_valid = 1'b0;
      #2 chk("rw7_old", r_resp_data, {X7, X7});
      step(); r_req_valid = 1'b0;
      #2 chk("rw7_new", r_resp_data, {Y7, Y7});

      // Reset in RUN with a buffered write and a response in flight.
      step();
      w_req_valid = 1'b1; w_req_idx = 7'd40; w_req_data = D40; w_req_waymask = 2'b11;
      r_req_valid = 1'b1; r_req_idx = 7'd40;
      step();
      w_req_valid = 1'b0; r_req_valid = 1'b0; reset_n = 1'b0;
      #2 chk("rst_run", {r_resp_valid, sram_en, init_done}, 3'b000);
      step(); reset_n = 1'b1;
      #2 chk("rerun_addr0", {sram_en, sram_wmode, sram_addr, sram_wdata}, {2'b11, 7'd0, 106'b0});
      repeat (128) step();

      for (int n = 0; n < 3000; n++) begin
         r_req_valid   = ($urandom % 4) != 0;
         r_req_idx     = 7'($urandom % 8);
         w_req_valid   = ($urandom % 3) == 0;
         w_req_idx     = 7'($urandom % 8);
         r64           = {$urandom, $urandom};
         w_req_data    = r64[52:0];
         w_req_waymask = 2'($urandom);
         step();
      end
      r_req_valid = 1'b0; w_req_valid = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
